// File: rtl/gf180mcu_fd_sc_mcu9t5v0_nand2_bist.sv
// Exhaustive stimulus/check wrapper for one NAND2 cell: sweeps {A1,A2}, samples ZN after
// a settle window, counts mismatches and records the first failing vector.
module gf180mcu_fd_sc_mcu9t5v0_nand2_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             A1,
  output logic             A2,
  input  logic             ZN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             FAIL_SEEN,
  output logic [1:0]       FAIL_VEC
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam int unsigned SLOT_W = 8;
  localparam int unsigned PCNT_W = 8;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SETTLE_CYCLES);
  localparam logic [PCNT_W-1:0] PASS_LAST = PCNT_W'(PASSES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state, state_nxt;
  logic [1:0]        vec, vec_nxt;
  logic [SLOT_W-1:0] slot, slot_nxt;
  logic [PCNT_W-1:0] pass_cnt, pass_cnt_nxt;
  logic              busy_nxt, done_nxt, pass_nxt, fail_seen_nxt;
  logic [CNT_W-1:0]  err_nxt, err_sum;
  logic [1:0]        fail_vec_nxt;
  logic              mismatch;

  // The driven vector is the registered sweep index itself; it rests at 00 outside a run.
  assign A1 = vec[1];
  assign A2 = vec[0];

  // Case-inequality so an X or Z on ZN is treated as a failure.
  assign mismatch = (ZN !== ~(vec[1] & vec[0]));

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    vec_nxt       = vec;
    slot_nxt      = slot;
    pass_cnt_nxt  = pass_cnt;
    busy_nxt      = BUSY;
    done_nxt      = DONE;
    pass_nxt      = PASS;
    err_nxt       = ERR_CNT;
    fail_seen_nxt = FAIL_SEEN;
    fail_vec_nxt  = FAIL_VEC;
    err_sum       = ERR_CNT;

    case (state)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          state_nxt     = ST_RUN;
          vec_nxt       = 2'b00;
          slot_nxt      = '0;
          pass_cnt_nxt  = '0;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          pass_nxt      = 1'b0;
          err_nxt       = '0;
          fail_seen_nxt = 1'b0;
          fail_vec_nxt  = 2'b00;
        end
      end
      ST_RUN: begin
        if (slot != SLOT_LAST) begin
          slot_nxt = slot + SLOT_W'(1);
        end else begin
          // End of slot: judge ZN for the vector currently driven, then advance.
          slot_nxt = '0;
          vec_nxt  = vec + 2'd1;
          if (mismatch) begin
            if (ERR_CNT != CNT_MAX) err_sum = ERR_CNT + CNT_W'(1);
            if (!FAIL_SEEN) begin
              fail_seen_nxt = 1'b1;
              fail_vec_nxt  = vec;
            end
          end
          err_nxt = err_sum;
          if (vec == 2'b11) begin
            if (pass_cnt == PASS_LAST) begin
              state_nxt = ST_FIN;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
              pass_nxt  = (err_sum == '0);
            end else begin
              pass_cnt_nxt = pass_cnt + PCNT_W'(1);
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      vec       <= 2'b00;
      slot      <= '0;
      pass_cnt  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_SEEN <= 1'b0;
      FAIL_VEC  <= 2'b00;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      slot      <= slot_nxt;
      pass_cnt  <= pass_cnt_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      PASS      <= pass_nxt;
      ERR_CNT   <= err_nxt;
      FAIL_SEEN <= fail_seen_nxt;
      FAIL_VEC  <= fail_vec_nxt;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_nand2_bist.sv
// Bench for the NAND2 BIST wrapper: four configurations, each driven by a faultable NAND model,
// checked cycle by cycle against a sweep-schedule reference and a mismatch scoreboard.
module tb_gf180mcu_fd_sc_mcu9t5v0_nand2_bist;

  logic       clk;
  logic       rst;
  logic [3:0] start;
  logic [3:0] zn;
  logic [3:0] a1, a2, busy, done, pass, fseen;
  logic [1:0] fvec [4];
  logic [7:0] err [4];
  logic [1:0] err_narrow;

  logic [3:0] fmask [4];
  logic [3:0] xmask [4];

  int unsigned s_cfg [4] = '{2, 2, 2, 0};
  int unsigned p_cfg [4] = '{1, 3, 2, 1};
  int unsigned w_cfg [4] = '{8, 8, 2, 8};

  int errors = 0;
  int checks = 0;

  gf180mcu_fd_sc_mcu9t5v0_nand2_bist #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(8)) d0 (
    .CLK(clk), .RST(rst), .START(start[0]), .A1(a1[0]), .A2(a2[0]), .ZN(zn[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(err[0]),
    .FAIL_SEEN(fseen[0]), .FAIL_VEC(fvec[0]));

  gf180mcu_fd_sc_mcu9t5v0_nand2_bist #(.SETTLE_CYCLES(2), .PASSES(3), .CNT_W(8)) d1 (
    .CLK(clk), .RST(rst), .START(start[1]), .A1(a1[1]), .A2(a2[1]), .ZN(zn[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(err[1]),
    .FAIL_SEEN(fseen[1]), .FAIL_VEC(fvec[1]));

  gf180mcu_fd_sc_mcu9t5v0_nand2_bist #(.SETTLE_CYCLES(2), .PASSES(2), .CNT_W(2)) d2 (
    .CLK(clk), .RST(rst), .START(start[2]), .A1(a1[2]), .A2(a2[2]), .ZN(zn[2]),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(err_narrow),
    .FAIL_SEEN(fseen[2]), .FAIL_VEC(fvec[2]));

  gf180mcu_fd_sc_mcu9t5v0_nand2_bist #(.SETTLE_CYCLES(0), .PASSES(1), .CNT_W(8)) d3 (
    .CLK(clk), .RST(rst), .START(start[3]), .A1(a1[3]), .A2(a2[3]), .ZN(zn[3]),
    .BUSY(busy[3]), .DONE(done[3]), .PASS(pass[3]), .ERR_CNT(err[3]),
    .FAIL_SEEN(fseen[3]), .FAIL_VEC(fvec[3]));

  assign err[2] = {6'b0, err_narrow};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NAND2 cell model with per-vector flip and X-injection faults.
  always_comb begin
    zn = '0;
    for (int i = 0; i < 4; i++) begin
      if (xmask[i][{a1[i], a2[i]}]) zn[i] = 1'bx;
      else                          zn[i] = ~(a1[i] & a2[i]) ^ fmask[i][{a1[i], a2[i]}];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input int i);
    check($sformatf("rst_ctl%0d", i), {28'd0, a1[i], a2[i], busy[i], done[i]}, 32'd0);
    check($sformatf("rst_res%0d", i), {20'd0, pass[i], fseen[i], fvec[i], err[i]}, 32'd0);
  endtask

  // Caller is at a negedge; START is seen by the next rising edge (edge 0).
  task automatic start_run(input int i, input bit hold);
    start[i] = 1'b1;
    @(negedge clk);
    if (!hold) start[i] = 1'b0;
  endtask

  // Walks one run from just after edge 0 to just after edge N, checking the sweep schedule
  // every cycle and scoring mismatches from the ZN the cell presents at each sample edge.
  task automatic run_cycles(input int i, input bit hold);
    int unsigned s = s_cfg[i];
    int unsigned n = p_cfg[i] * 4 * (s + 1);
    int unsigned sat = (1 << w_cfg[i]) - 1;
    int exp_cnt = 0;
    int first = -1;
    logic [1:0] exp_a;
    for (int k = 0; k <= int'(n); k++) begin
      exp_a = (k < int'(n)) ? 2'((k / int'(s + 1)) % 4) : 2'b00;
      check($sformatf("ctl%0d_k%0d", i, k), {28'd0, busy[i], done[i], a1[i], a2[i]},
            {28'd0, 1'(k < int'(n)), 1'(k == int'(n)), exp_a});
      if (k < int'(n) && ((k + 1) % int'(s + 1)) == 0) begin
        if (zn[i] !== ~(exp_a[1] & exp_a[0])) begin
          exp_cnt++;
          if (first < 0) first = int'(exp_a);
        end
      end
      if (k == int'(n)) break;
      if (!hold) begin
        if (start[i]) start[i] = 1'b0;
        else if (k + 2 < int'(n) && $urandom_range(0, 7) == 0) start[i] = 1'b1;
      end
      @(negedge clk);
    end
    check($sformatf("err%0d", i), 32'(err[i]), (exp_cnt > int'(sat)) ? sat : 32'(exp_cnt));
    check($sformatf("fseen%0d", i), 32'(fseen[i]), 32'(exp_cnt > 0));
    if (exp_cnt > 0) check($sformatf("fvec%0d", i), 32'(fvec[i]), 32'(first));
    check($sformatf("pass%0d", i), 32'(pass[i]), 32'(exp_cnt == 0));
  endtask

  task automatic full_run(input int i, input logic [3:0] f, input logic [3:0] x);
    fmask[i] = f;
    xmask[i] = x;
    start_run(i, 1'b0);
    run_cycles(i, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < 4; i++) begin
      fmask[i] = '0;
      xmask[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check_reset_state(i);
    rst = 1'b0;
    @(negedge clk);

    full_run(0, 4'b0000, 4'b0000);  // ideal cell
    full_run(0, 4'b1000, 4'b0000);  // stuck-at-1
    full_run(1, 4'b0111, 4'b0000);  // stuck-at-0, three passes
    full_run(2, 4'b0111, 4'b0000);  // stuck-at-0, narrow saturating counter

    // Reset mid-run, with START also high to confirm reset wins.
    fmask[0] = 4'b0000;
    start_run(0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    check_reset_state(0);
    rst = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    check_reset_state(0);
    full_run(0, 4'b0000, 4'b0000);

    // X on vector 01 with zero settle, START held through FIN for an immediate restart.
    fmask[3] = 4'b0000;
    xmask[3] = 4'b0010;
    start_run(3, 1'b1);
    run_cycles(3, 1'b1);
    @(negedge clk);
    check("restart_ctl", {28'd0, busy[3], done[3], a1[3], a2[3]}, 32'b1000);
    check("restart_clr", {20'd0, pass[3], fseen[3], fvec[3], err[3]}, 32'd0);
    start[3] = 1'b0;
    xmask[3] = 4'b0000;
    run_cycles(3, 1'b0);

    // Random fault patterns across all configurations.
    for (int r = 0; r < 12; r++) begin
      int i = int'($urandom_range(0, 3));
      logic [3:0] f = 4'($urandom);
      logic [3:0] x = 4'($urandom) & 4'b0111 & ~f;
      full_run(i, f, x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
